// File: rtl/riscv_dmem.sv
// Byte-addressable data memory for the RISC-V EX-stage interface: LB/LH/LW/LBU/LHU, SB/SH/SW.
// Define DMEM_MISALIGN_SPLIT_EN to service misaligned accesses as two-cycle split accesses.
module riscv_dmem #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_dmem_en,
  input  logic        i_dmem_we,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_wdata,
  input  logic [2:0]  i_dmem_funct3,
  output logic        o_dmem_ready,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_rvalid,
  output logic        o_dmem_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] W_LIMIT = 33'(DEPTH_WORDS * 4);
  localparam logic [AW-1:0] W_ONE = 1;
`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic {ST_IDLE, ST_SPLIT} state_t;

  function automatic logic [3:0] f_lane_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] f_nbytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  logic [31:0]   r_mem [DEPTH_WORDS];
  state_t        r_state;
  logic          r_rvalid;
  logic          r_err;
  logic          r_split_data;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_off;
  logic [2:0]    r_f3;
  logic          r_we;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rd_word;
  logic [31:0]   r_lo_word;

  logic          w_idle;
  logic          w_accept;
  logic          w_f3_bad;
  logic [32:0]   w_last;
  logic          w_oob;
  logic          w_misal;
  logic          w_illegal;
  logic [1:0]    w_src_off;
  logic [1:0]    w_src_sz;
  logic [31:0]   w_src_data;
  logic [7:0]    w_mask8;
  logic [63:0]   w_data64;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wr_lanes;
  logic [63:0]   w_dword;
  logic [31:0]   w_sel;
  logic [31:0]   w_ext;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = i_rst_n && i_dmem_en && w_idle;

  // Legality of the incoming request; the last touched byte bounds the range check.
  assign w_f3_bad  = (i_dmem_funct3 == 3'b011) || (i_dmem_funct3[2:1] == 2'b11) ||
                     (i_dmem_funct3[2] && i_dmem_we);
  assign w_last    = {1'b0, i_dmem_addr} + {30'd0, f_nbytes(i_dmem_funct3[1:0])} - 33'd1;
  assign w_oob     = (w_last >= W_LIMIT);
  assign w_misal   = ((i_dmem_funct3[1:0] == 2'b01) && i_dmem_addr[0]) ||
                     ((i_dmem_funct3[1:0] == 2'b10) && (i_dmem_addr[1:0] != 2'b00));
  assign w_illegal = w_f3_bad || w_oob || (w_misal && !SPLIT_EN);

  // Store data and lane mask are laid out across two words; SPLIT writes the upper half.
  assign w_src_off  = w_idle ? i_dmem_addr[1:0] : r_off;
  assign w_src_sz   = w_idle ? i_dmem_funct3[1:0] : r_f3[1:0];
  assign w_src_data = w_idle ? i_dmem_wdata : r_wdata;
  assign w_mask8    = {4'b0000, f_lane_mask(w_src_sz)} << w_src_off;
  assign w_data64   = {32'd0, w_src_data} << {w_src_off, 3'b000};
  assign w_idx      = w_idle ? i_dmem_addr[AW+1:2] : r_idx + W_ONE;
  assign w_wr_lanes = w_idle ? w_data64[31:0] : w_data64[63:32];

  always_comb begin
    w_be = 4'b0000;
    if (w_idle) begin
      if (w_accept && !w_illegal && i_dmem_we) w_be = w_mask8[3:0];
    end else if (i_rst_n && r_we) begin
      w_be = w_mask8[7:4];
    end
  end

  always_ff @(posedge i_clk) begin
    for (int l = 0; l < 4; l++) begin
      if (w_be[l]) r_mem[w_idx][l*8 +: 8] <= w_wr_lanes[l*8 +: 8];
    end
    r_rd_word <= r_mem[w_idx];
    if (!w_idle) r_lo_word <= r_rd_word;
    if (w_accept) begin
      r_idx   <= i_dmem_addr[AW+1:2];
      r_off   <= i_dmem_addr[1:0];
      r_f3    <= i_dmem_funct3;
      r_we    <= i_dmem_we;
      r_wdata <= i_dmem_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_rvalid     <= 1'b0;
      r_err        <= 1'b0;
      r_split_data <= 1'b0;
    end else begin
      r_rvalid     <= 1'b0;
      r_err        <= 1'b0;
      r_split_data <= !w_idle;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_illegal)    r_err    <= 1'b1;
            else if (w_misal) r_state  <= ST_SPLIT;
            else              r_rvalid <= !i_dmem_we;
          end
        end
        default: begin
          r_rvalid <= !r_we;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Split loads combine the saved lower word with the freshly read upper word.
  assign w_dword = r_split_data ? {r_rd_word, r_lo_word} : {32'd0, r_rd_word};
  assign w_sel   = 32'(w_dword >> {r_off, 3'b000});

  always_comb begin
    w_ext = w_sel;
    case (r_f3)
      3'b000:  w_ext = {{24{w_sel[7]}}, w_sel[7:0]};
      3'b001:  w_ext = {{16{w_sel[15]}}, w_sel[15:0]};
      3'b100:  w_ext = {24'd0, w_sel[7:0]};
      3'b101:  w_ext = {16'd0, w_sel[15:0]};
      default: w_ext = w_sel;
    endcase
  end

`ifdef DMEM_MISALIGN_SPLIT_EN
  assign o_dmem_ready = w_idle;
`else
  assign o_dmem_ready = 1'b1;
`endif
  assign o_dmem_rdata  = r_rvalid ? w_ext : 32'd0;
  assign o_dmem_rvalid = r_rvalid;
  assign o_dmem_err    = r_err;

endmodule

// File: tb/tb_riscv_dmem.sv
// Self-checking bench for riscv_dmem: byte-level memory model plus literal spot checks.
`timescale 1ns/1ps
module tb_riscv_dmem;
  localparam int DEPTH  = 64;
  localparam int NBYTES = DEPTH * 4;
  localparam int MAXC   = 2048;
`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [2:0]  f3 = 3'd0;
  logic        ready, rvalid, err;
  logic [31:0] rdata;

  riscv_dmem #(.DEPTH_WORDS(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_dmem_en(en), .i_dmem_we(we),
    .i_dmem_addr(addr), .i_dmem_wdata(wdata), .i_dmem_funct3(f3),
    .o_dmem_ready(ready), .o_dmem_rdata(rdata), .o_dmem_rvalid(rvalid), .o_dmem_err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_checks = 0;
  logic [7:0]  mm [NBYTES];
  bit          exp_ready [MAXC];
  bit          exp_rv [MAXC];
  bit          exp_err [MAXC];
  logic [31:0] exp_data [MAXC];
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
  endtask

  function automatic int nbytes(input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_misal(input logic [2:0] f, input logic [31:0] a);
    return ((f[1:0] == 2'b01) && a[0]) || ((f[1:0] == 2'b10) && (a[1:0] != 2'b00));
  endfunction

  function automatic bit is_illegal(input logic [2:0] f, input bit w, input logic [31:0] a);
    longint last_excl;
    last_excl = longint'(a) + longint'(nbytes(f));
    return (f == 3'b011) || (f == 3'b110) || (f == 3'b111) || (f[2] && w) ||
           (last_excl > longint'(NBYTES)) || (is_misal(f, a) && !SPLIT);
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f, input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < nbytes(f); i++) v[8*i +: 8] = mm[int'(a) + i];
    case (f)
      3'b000:  v = {{24{v[7]}}, v[7:0]};
      3'b001:  v = {{16{v[15]}}, v[15:0]};
      default: ;
    endcase
    return v;
  endfunction

  // Drives one request (held through SPLIT) and records what the outputs must show.
  task automatic req(input bit w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int c;
    bit ill, sp;
    c   = cyc;
    ill = is_illegal(f, w, a);
    sp  = !ill && is_misal(f, a);
    en = 1'b1; we = w; f3 = f; addr = a; wdata = d;
    if (ill) begin
      exp_err[c+1] = 1'b1;
    end else begin
      if (sp) exp_ready[c+1] = 1'b0;
      if (!w) begin
        exp_rv[c+1+int'(sp)]   = 1'b1;
        exp_data[c+1+int'(sp)] = load_val(f, a);
      end else begin
        for (int i = 0; i < nbytes(f); i++) mm[int'(a) + i] = d[8*i +: 8];
      end
    end
    $display("cycle %0d %s f3=%0d addr=0x%08h wdata=0x%08h -> %s", c, w ? "ST" : "LD", f, a, d,
             ill ? "err" : (sp ? "split" : "ok"));
    @(posedge clk); #1;
    if (sp) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load_lit(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] lit);
    req(1'b0, f, a, 32'd0);
    en = 1'b0;
    @(negedge clk);
    check(name, rdata, lit);
    @(posedge clk); #1;
  endtask

  task automatic err_lit(input string name, input bit w, input logic [2:0] f, input logic [31:0] a);
    req(w, f, a, 32'h5555_5555);
    en = 1'b0;
    @(negedge clk);
    check(name, {31'd0, err}, 32'd1);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      check("ready", {31'd0, ready}, {31'd0, exp_ready[cyc]});
      check("rvalid", {31'd0, rvalid}, {31'd0, exp_rv[cyc]});
      check("err", {31'd0, err}, {31'd0, exp_err[cyc]});
      if (exp_rv[cyc]) check("rdata", rdata, exp_data[cyc]);
      if (exp_err[cyc]) check("err_rdata", rdata, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      exp_ready[i] = 1'b1; exp_rv[i] = 1'b0; exp_err[i] = 1'b0; exp_data[i] = 32'd0;
    end
    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < DEPTH; i++) req(1'b1, 3'b010, 32'(i * 4), 32'(32'h0101_0101 * i) + 32'h1357_9BDF);
    idle(1);
    load_lit("lw_pre0", 3'b010, 32'h0, 32'h1357_9BDF);

    req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    load_lit("lw_raw", 3'b010, 32'h10, 32'hDEAD_BEEF);
    load_lit("lh_sign", 3'b001, 32'h12, 32'hFFFF_DEAD);
    load_lit("lhu_zero", 3'b101, 32'h12, 32'h0000_DEAD);

    req(1'b1, 3'b000, 32'h21, 32'h1234_5680);
    load_lit("lb_sign", 3'b000, 32'h21, 32'hFFFF_FF80);
    load_lit("lbu_zero", 3'b100, 32'h21, 32'h0000_0080);

    req(1'b1, 3'b001, 32'h32, 32'hABCD_1234);
    load_lit("lhu_sh", 3'b101, 32'h32, 32'h0000_1234);
    load_lit("lw_sh", 3'b010, 32'h30, 32'h1234_A7EB);

    err_lit("lw_oob_err", 1'b0, 3'b010, 32'h100);
    err_lit("sw_oob_err", 1'b1, 3'b010, 32'h100);
    req(1'b1, 3'b000, 32'h8000_0000, 32'h0000_00FF);
    load_lit("lw_word0", 3'b010, 32'h0, 32'h1357_9BDF);

    err_lit("f3_011_err", 1'b0, 3'b011, 32'h20);
    err_lit("lbu_store_err", 1'b1, 3'b100, 32'h24);
    req(1'b0, 3'b110, 32'h24, 32'd0);
    req(1'b1, 3'b111, 32'h24, 32'hFFFF_FFFF);
    load_lit("lw_after_bad", 3'b010, 32'h24, 32'h1C60_A4E8);

    load_lit("lw_top", 3'b010, 32'hFC, 32'h5296_DB1E);
    load_lit("lb_top", 3'b000, 32'hFF, 32'h0000_0052);
    load_lit("lbu_fc", 3'b100, 32'hFC, 32'h0000_001E);
    err_lit("lh_ff_err", 1'b0, 3'b001, 32'hFF);
    req(1'b1, 3'b001, 32'hFE, 32'h0000_CAFE);
    load_lit("lhu_fe", 3'b101, 32'hFE, 32'h0000_CAFE);
    load_lit("lh_fe", 3'b001, 32'hFE, 32'hFFFF_CAFE);
    err_lit("sw_fd_err", 1'b1, 3'b010, 32'hFD);
    load_lit("lw_top2", 3'b010, 32'hFC, 32'hCAFE_DB1E);

`ifdef DMEM_MISALIGN_SPLIT_EN
    req(1'b1, 3'b010, 32'h41, 32'hAABB_CCDD);
    load_lit("lw_mis", 3'b010, 32'h41, 32'hAABB_CCDD);
    load_lit("lw_mis_lo", 3'b010, 32'h40, 32'hBBCC_DDEF);
    load_lit("lw_mis_hi", 3'b010, 32'h44, 32'h2468_ACAA);
    load_lit("lh_mis_in", 3'b001, 32'h11, 32'hFFFF_ADBE);
    load_lit("lh_mis_x", 3'b001, 32'h13, 32'hFFFF_E4DE);
`else
    err_lit("sw_mis_err", 1'b1, 3'b010, 32'h41);
    err_lit("lw_mis_err", 1'b0, 3'b010, 32'h41);
    err_lit("lh_mis_err", 1'b0, 3'b001, 32'h13);
    load_lit("lw_mis_lo", 3'b010, 32'h40, 32'h2367_ABEF);
    load_lit("lw_mis_hi", 3'b010, 32'h44, 32'h2468_ACF0);
`endif

    req(1'b0, 3'b010, 32'h10, 32'd0);
    req(1'b0, 3'b100, 32'h22, 32'd0);
    req(1'b0, 3'b001, 32'h30, 32'd0);
    req(1'b1, 3'b000, 32'h13, 32'h0000_0077);
    req(1'b0, 3'b000, 32'h13, 32'd0);
    req(1'b0, 3'b010, 32'h24, 32'd0);
    req(1'b0, 3'b010, 32'h43, 32'd0);
    idle(2);

    chk_en = 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
    mm[32'h43] = 8'h44;
    $display("cycle %0d ST f3=2 addr=0x00000043 wdata=0x11223344 -> reset during split", cyc);
    en = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h43; wdata = 32'h1122_3344;
    @(posedge clk); #1;
    check("split_ready_low", {31'd0, ready}, 32'd0);
`else
    $display("cycle %0d reset pulse while idle", cyc);
`endif
    rst_n = 1'b0; en = 1'b0;
    #1;
    check("rst2_ready", {31'd0, ready}, 32'd1);
    check("rst2_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst2_err", {31'd0, err}, 32'd0);
    check("rst2_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(1);
`ifdef DMEM_MISALIGN_SPLIT_EN
    load_lit("lw_rst_lo", 3'b010, 32'h40, 32'h44CC_DDEF);
    load_lit("lw_rst_hi", 3'b010, 32'h44, 32'h2468_ACAA);
`else
    load_lit("lw_rst_lo", 3'b010, 32'h40, 32'h2367_ABEF);
    load_lit("lw_rst_hi", 3'b010, 32'h44, 32'h2468_ACF0);
`endif
    idle(3);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
